sha2_chunk_engine: RTL

Parametrised SHA-2 compression engine that generalises the single-width SHA-512 chunk block. WORD_W selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds). UNROLL sets the number of rounds per cycle. The engine uses a valid/ready handshake on input and output so a message-level controller can stream chunks. It also uses a rolling 16-word schedule instead of a full W array.

---
 rtl/sha2_pkg.sv | 98 +++++++++
 rtl/sha2_chunk_engine_if.sv | 26 ++
 rtl/sha2_round.sv | 23 ++
 rtl/sha2_chunk_engine.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 constants, FSM states and sigma helpers shared by the chunk engine
// Purpose: round constants K256/K512, initial hash values IV256/IV512 (H0 in the MSBs),
//          engine state enum and per-width rotation amounts. No ports.
package sha2_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} sha2_state_e;

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    localparam logic [31:0] K256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // Rotation amounts: small sigmas are {rotr, rotr, shr}, big sigmas are three rotr.
    localparam int SS0_64 [0:2] = '{1, 8, 7};
    localparam int SS1_64 [0:2] = '{19, 61, 6};
    localparam int BS0_64 [0:2] = '{28, 34, 39};
    localparam int BS1_64 [0:2] = '{14, 18, 41};
    localparam int SS0_32 [0:2] = '{7, 18, 3};
    localparam int SS1_32 [0:2] = '{17, 19, 10};
    localparam int BS0_32 [0:2] = '{2, 13, 22};
    localparam int BS1_32 [0:2] = '{6, 11, 25};

    // Helpers work on a 64-bit carrier; 32-bit words live in the low half.
    function automatic logic [63:0] word_mask(input int w);
        return (w == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] xm;
        xm = x & word_mask(w);
        return ((xm >> n) | (xm << (w - n))) & word_mask(w);
    endfunction

    function automatic logic [63:0] ssig(input logic [63:0] x, input int r0, input int r1, input int sh, input int w);
        return rotr(x, r0, w) ^ rotr(x, r1, w) ^ ((x & word_mask(w)) >> sh);
    endfunction

    function automatic logic [63:0] bsig(input logic [63:0] x, input int r0, input int r1, input int r2, input int w);
        return rotr(x, r0, w) ^ rotr(x, r1, w) ^ rotr(x, r2, w);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int w);
        return (w == 64) ? ssig(x, SS0_64[0], SS0_64[1], SS0_64[2], 64) : ssig(x, SS0_32[0], SS0_32[1], SS0_32[2], 32);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int w);
        return (w == 64) ? ssig(x, SS1_64[0], SS1_64[1], SS1_64[2], 64) : ssig(x, SS1_32[0], SS1_32[1], SS1_32[2], 32);
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x, input int w);
        return (w == 64) ? bsig(x, BS0_64[0], BS0_64[1], BS0_64[2], 64) : bsig(x, BS0_32[0], BS0_32[1], BS0_32[2], 32);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x, input int w);
        return (w == 64) ? bsig(x, BS1_64[0], BS1_64[1], BS1_64[2], 64) : bsig(x, BS1_32[0], BS1_32[1], BS1_32[2], 32);
    endfunction

    // Out-of-range indices return 0 so idle-state lookups stay in bounds.
    function automatic logic [63:0] k_word(input logic [6:0] idx, input int w);
        if (w == 64) return (idx < 7'd80) ? K512[idx] : 64'h0;
        return (idx < 7'd64) ? {32'h0, K256[idx[5:0]]} : 64'h0;
    endfunction

endpackage

// File: rtl/sha2_chunk_engine_if.sv
// rtl/sha2_chunk_engine_if.sv - chunk/result handshake bundle for sha2_chunk_engine
// Signals: in_valid/in_ready/chunk/h_in (chunk input), out_valid/out_ready/h_out (result),
//          busy (status), in_first (only with SHA2_CHUNK_CHAIN_EN).
// Modports: master = chunk producer / result consumer, slave = engine.
interface sha2_chunk_engine_if #(parameter int WORD_W = 64) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORD_W-1:0]  chunk;
    logic [8*WORD_W-1:0]   h_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*WORD_W-1:0]   h_out;
    logic                  busy;
`ifdef SHA2_CHUNK_CHAIN_EN
    logic                  in_first;
    modport master (output in_valid, chunk, h_in, in_first, out_ready,
                    input  in_ready, out_valid, h_out, busy);
    modport slave  (input  in_valid, chunk, h_in, in_first, out_ready,
                    output in_ready, out_valid, h_out, busy);
`else
    modport master (output in_valid, chunk, h_in, out_ready,
                    input  in_ready, out_valid, h_out, busy);
    modport slave  (input  in_valid, chunk, h_in, out_ready,
                    output in_ready, out_valid, h_out, busy);
`endif
endinterface

// File: rtl/sha2_round.sv
// rtl/sha2_round.sv - one combinational SHA-2 compression round
// Ports: st_i = {a..h} (a in MSBs), w_i = schedule word, k_i = round constant,
//        st_o = next {a..h}. WORD_W selects the 32- or 64-bit sigma set.
module sha2_round
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [8*WORD_W-1:0] st_i,
    input  logic [WORD_W-1:0]   w_i,
    input  logic [WORD_W-1:0]   k_i,
    output logic [8*WORD_W-1:0] st_o
);
    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] ch, maj, t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_i;
    assign ch   = (e & f) ^ (~e & g);
    assign maj  = (a & b) ^ (a & c) ^ (b & c);
    assign t1   = h + WORD_W'(bsig1(64'(e), WORD_W)) + ch + k_i + w_i;
    assign t2   = WORD_W'(bsig0(64'(a), WORD_W)) + maj;
    assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha2_chunk_engine.sv
// rtl/sha2_chunk_engine.sv - SHA-256/SHA-512 chunk compression engine, UNROLL rounds per clock
// Ports: clk, reset (async, active-low), bus (sha2_chunk_engine_if.slave: chunk in, digest out, busy).
// Parameters: WORD_W 32 (SHA-256) or 64 (SHA-512); UNROLL 1, 2 or 4.
// Macro SHA2_CHUNK_CHAIN_EN: in_first=0 chains from the previous h_out instead of h_in.
module sha2_chunk_engine
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    sha2_chunk_engine_if.slave bus
);
    localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_width
        $error("sha2_chunk_engine: WORD_W must be 32 or 64");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("sha2_chunk_engine: UNROLL must be 1, 2 or 4");
    end

    sha2_state_e         state_q, state_d;
    logic [6:0]          t_q, t_d;
    logic [WORD_W-1:0]   w_q [16];
    logic [WORD_W-1:0]   w_d [16];
    logic [WORD_W-1:0]   w_new [UNROLL];
    logic [8*WORD_W-1:0] st_q, st_d, hreg_q, hreg_d, h_out_q, h_out_d;
    logic [8*WORD_W-1:0] st_next, h_sum, cv;

    // w_q[0] is W[t]; each ROUND cycle consumes w_q[0..UNROLL-1] and appends UNROLL new words.
    for (genvar j = 0; j < UNROLL; j++) begin : g_sched
        logic [WORD_W-1:0] w14, nw;
        if (j < 2) begin : g_old
            assign w14 = w_q[j+14];
        end else begin : g_fwd
            // W[t+j+14] was produced by this same cycle's expansion two slots earlier.
            assign w14 = g_sched[j-2].nw;
        end
        assign nw = w_q[j] + WORD_W'(ssig0(64'(w_q[j+1]), WORD_W)) + w_q[j+9]
                  + WORD_W'(ssig1(64'(w14), WORD_W));
        assign w_new[j] = nw;
    end

    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [8*WORD_W-1:0] st_in, st_out;
        logic [WORD_W-1:0]   k_j;
        if (j == 0) begin : g_first
            assign st_in = st_q;
        end else begin : g_chain
            assign st_in = g_rnd[j-1].st_out;
        end
        assign k_j = WORD_W'(k_word(t_q + 7'(j), WORD_W));
        sha2_round #(.WORD_W(WORD_W)) u_round (
            .st_i (st_in),
            .w_i  (w_q[j]),
            .k_i  (k_j),
            .st_o (st_out)
        );
    end
    assign st_next = g_rnd[UNROLL-1].st_out;

    for (genvar i = 0; i < 8; i++) begin : g_sum
        assign h_sum[i*WORD_W +: WORD_W] = hreg_q[i*WORD_W +: WORD_W] + st_q[i*WORD_W +: WORD_W];
    end

`ifdef SHA2_CHUNK_CHAIN_EN
    // h_out_q already holds the last digest and is cleared by reset, so it doubles as the chain register.
    assign cv = bus.in_first ? bus.h_in : h_out_q;
`else
    assign cv = bus.h_in;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        st_d    = st_q;
        hreg_d  = hreg_q;
        h_out_d = h_out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = bus.chunk[(16-i)*WORD_W-1 -: WORD_W];
                    end
                    hreg_d  = cv;
                    st_d    = cv;
                    t_d     = 7'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = st_next;
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = (i + UNROLL < 16) ? w_q[i+UNROLL] : w_new[i+UNROLL-16];
                end
                if (t_q == 7'(ROUNDS - UNROLL)) begin
                    state_d = FINAL;
                end else begin
                    t_d = t_q + 7'(UNROLL);
                end
            end
            FINAL: begin
                h_out_d = h_sum;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            t_q     <= 7'd0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            st_q    <= '0;
            hreg_q  <= '0;
            h_out_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            st_q    <= st_d;
            hreg_q  <= hreg_d;
            h_out_q <= h_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ROUND) || (state_q == FINAL);
    assign bus.h_out     = h_out_q;
endmodule
